// File: rtl/bcd_display_sequencer_if.sv
// Handshake and result bundle for bcd_display_sequencer.
//   master modport: the requester, which drives START/V and observes the status and result.
//   slave  modport: the sequencer, which samples START/V and drives BUSY, DONE, BCD and HEX.
//   START : conversion request, sampled on the rising clock edge.
//   V     : unsigned binary value, sampled only on the edge that accepts START.
//   BUSY  : high while a conversion is in progress.
//   DONE  : one-cycle pulse when a new result becomes valid.
//   BCD   : packed BCD result; digit 0 (units) sits in [3:0].
//   HEX   : active-low segment patterns; digit i sits in [7i+6:7i], bit order g..a.
interface bcd_display_sequencer_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  START;
  logic [WIDTH-1:0]      V;
  logic                  BUSY;
  logic                  DONE;
  logic [4*DIGITS-1:0]   BCD;
  logic [7*DIGITS-1:0]   HEX;

  modport master (output START, V, input BUSY, DONE, BCD, HEX);
  modport slave  (input START, V, output BUSY, DONE, BCD, HEX);
endinterface

// File: rtl/bcd_display_sequencer.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock) that drives
// one active-low seven-segment pattern per decimal digit.
//   CLOCK_50 : system clock; all state changes happen on its rising edge.
//   RESET_N  : asynchronous active-low reset. It aborts any conversion in flight.
//   bus      : slave side of bcd_display_sequencer_if (START/V in; BUSY/DONE/BCD/HEX out).
// Parameters:
//   WIDTH    : width of the binary input.
//   DIGITS   : number of BCD digits. It must cover 2^WIDTH-1.
//   BLANK_LZ : 1 blanks leading-zero digits. Digit 0 is always shown.
module bcd_display_sequencer #(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter int BLANK_LZ = 1
) (
  input  logic                     CLOCK_50,
  input  logic                     RESET_N,
  bcd_display_sequencer_if.slave   bus
);

  localparam int SW = 4 * DIGITS;
  localparam int HW = 7 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  // Saturating 10^n, so that very wide DIGITS settings do not overflow the range check.
  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      if (p > 64'd1844674407370955161) p = '1;
      else                             p = p * 64'd10;
    end
    return p;
  endfunction

  localparam longint unsigned VMAX = (WIDTH >= 64) ? '1 : ((64'd1 << WIDTH) - 64'd1);

  generate
    if (pow10(DIGITS) <= VMAX) begin : g_digits_too_few
      $error("bcd_display_sequencer: DIGITS too small to hold 2^WIDTH-1");
    end
  endgenerate

  // Active-low segment pattern for one BCD digit, bit order g..a.
  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  endfunction

  // Full display image for a packed BCD word. The scan runs from the most significant
  // digit downwards, so nz means "this digit or a higher one is non-zero".
  function automatic logic [HW-1:0] hex_of(input logic [SW-1:0] b);
    logic [HW-1:0] h;
    logic          nz;
    h  = '0;
    nz = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nz = nz | (b[4*i +: 4] != 4'd0);
      if (BLANK_LZ != 0 && i != 0 && !nz) h[7*i +: 7] = 7'b1111111;
      else                                h[7*i +: 7] = seg(b[4*i +: 4]);
    end
    return h;
  endfunction

  localparam logic [HW-1:0] HEX_RST = hex_of('0);

  typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

  state_t          state_reg;
  logic [WIDTH-1:0] bin_reg;
  logic [SW-1:0]   scratch_reg;
  logic [CW-1:0]   cnt_reg;
  logic            busy_reg;
  logic            done_reg;
  logic [SW-1:0]   bcd_reg;
  logic [HW-1:0]   hex_reg;

  logic [SW-1:0]   scratch_adj;
  logic [SW-1:0]   scratch_next;
  logic [WIDTH-1:0] bin_next;
  logic [HW-1:0]   hex_next;

  // Add-3 correction on every digit in parallel, applied before the shift.
  // A digit of 5..9 becomes 8..12, so the shift carries into the next digit correctly.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_add3
      assign scratch_adj[4*gi +: 4] = (scratch_reg[4*gi +: 4] >= 4'd5)
                                    ? scratch_reg[4*gi +: 4] + 4'd3
                                    : scratch_reg[4*gi +: 4];
    end
  endgenerate

  assign scratch_next = {scratch_adj[SW-2:0], bin_reg[WIDTH-1]};
  assign bin_next     = bin_reg << 1;
  assign hex_next     = hex_of(scratch_next);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg   <= IDLE;
      bin_reg     <= '0;
      scratch_reg <= '0;
      cnt_reg     <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      bcd_reg     <= '0;
      hex_reg     <= HEX_RST;
    end else begin
      case (state_reg)
        // FIN accepts a new request exactly as IDLE does, which allows back-to-back conversions.
        IDLE, FIN: begin
          done_reg <= 1'b0;
          if (bus.START) begin
            bin_reg     <= bus.V;
            scratch_reg <= '0;
            cnt_reg     <= CW'(WIDTH);
            busy_reg    <= 1'b1;
            state_reg   <= SHIFT;
          end else begin
            state_reg   <= IDLE;
          end
        end
        SHIFT: begin
          scratch_reg <= scratch_next;
          bin_reg     <= bin_next;
          cnt_reg     <= cnt_reg - CW'(1);
          // The final iteration publishes its shifted value directly, so BCD and HEX
          // never show an intermediate scratch value.
          if (cnt_reg == CW'(1)) begin
            bcd_reg   <= scratch_next;
            hex_reg   <= hex_next;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= FIN;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.BUSY = busy_reg;
  assign bus.DONE = done_reg;
  assign bus.BCD  = bcd_reg;
  assign bus.HEX  = hex_reg;

endmodule

// File: tb/tb_bcd_display_sequencer.sv
// Directed testbench for bcd_display_sequencer. It drives two instances side by side,
// one with leading-zero blanking and one without, using identical stimulus.
module tb_bcd_display_sequencer;

  logic CLOCK_50;
  logic RESET_N;

  bcd_display_sequencer_if #(.WIDTH(8), .DIGITS(3)) ifb ();
  bcd_display_sequencer_if #(.WIDTH(8), .DIGITS(3)) ifn ();

  bcd_display_sequencer #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(1)) dut_b (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .bus      (ifb)
  );

  bcd_display_sequencer #(.WIDTH(8), .DIGITS(3), .BLANK_LZ(0)) dut_n (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .bus      (ifn)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] SB = 7'b1111111;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic drive(input logic s, input logic [7:0] v);
    ifb.START = s;
    ifn.START = s;
    ifb.V     = v;
    ifn.V     = v;
  endtask

  function automatic logic [6:0] seg_ref(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [11:0] bcd_ref(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [20:0] hex_ref(input int v, input bit blank);
    int d2, d1, d0;
    logic [6:0] h2, h1, h0;
    d2 = v / 100 % 10;
    d1 = v / 10 % 10;
    d0 = v % 10;
    h2 = (blank && d2 == 0) ? SB : seg_ref(d2);
    h1 = (blank && d2 == 0 && d1 == 0) ? SB : seg_ref(d1);
    h0 = seg_ref(d0);
    return {h2, h1, h0};
  endfunction

  // Counts edges from the accept edge until DONE. It gives up after 20 edges.
  task automatic wait_done(input string tag, output int lat);
    lat = 0;
    while (!ifb.DONE && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd8);
  endtask

  task automatic check_result(input string tag, input int v);
    chk({tag, "_bcd_b"}, 64'(ifb.BCD), 64'(bcd_ref(v)));
    chk({tag, "_bcd_n"}, 64'(ifn.BCD), 64'(bcd_ref(v)));
    chk({tag, "_hex_b"}, 64'(ifb.HEX), 64'(hex_ref(v, 1'b1)));
    chk({tag, "_hex_n"}, 64'(ifn.HEX), 64'(hex_ref(v, 1'b0)));
  endtask

  // Single conversion from IDLE. It returns in the DONE cycle.
  task automatic run(input string tag, input int v);
    int lat;
    drive(1'b1, 8'(v));
    tick();
    drive(1'b0, 8'd0);
    chk({tag, "_busy_k"}, 64'(ifb.BUSY), 64'd1);
    wait_done(tag, lat);
    chk({tag, "_done"}, 64'(ifb.DONE), 64'd1);
    chk({tag, "_busy_fin"}, 64'(ifb.BUSY), 64'd0);
    check_result(tag, v);
    $display("run %s: V=%0d BCD=%03h HEX_b=%021b latency=%0d", tag, v, ifb.BCD, ifb.HEX, lat);
  endtask

  initial begin
    int lat;
    int dones;
    int busies;

    RESET_N = 1'b0;
    drive(1'b0, 8'd0);
    repeat (3) tick();

    // Reset values.
    chk("rst_bcd_b", 64'(ifb.BCD), 64'h000);
    chk("rst_bcd_n", 64'(ifn.BCD), 64'h000);
    chk("rst_hex_b", 64'(ifb.HEX), 64'({SB, SB, S0}));
    chk("rst_hex_n", 64'(ifn.HEX), 64'({S0, S0, S0}));
    chk("rst_busy",  64'(ifb.BUSY), 64'd0);
    chk("rst_done",  64'(ifb.DONE), 64'd0);
    $display("reset: BCD=%03h HEX_b=%021b HEX_n=%021b", ifb.BCD, ifb.HEX, ifn.HEX);

    RESET_N = 1'b1;
    repeat (2) tick();
    chk("idle_busy", 64'(ifb.BUSY), 64'd0);
    chk("idle_done", 64'(ifb.DONE), 64'd0);

    // Maximum value. All three digits are significant.
    run("v255", 255);
    chk("v255_bcd_lit", 64'(ifb.BCD), 64'h255);
    chk("v255_hex_lit", 64'(ifb.HEX), 64'({7'b0100100, 7'b0010010, 7'b0010010}));
    tick();
    chk("v255_done_pulse", 64'(ifb.DONE), 64'd0);
    chk("v255_hold", 64'(ifb.BCD), 64'h255);

    // Single digit: both upper digits are blanked only in the BLANK_LZ=1 instance.
    run("v7", 7);
    chk("v7_hex_b_lit", 64'(ifb.HEX), 64'({SB, SB, 7'b1111000}));
    chk("v7_hex_n_lit", 64'(ifn.HEX), 64'({S0, S0, 7'b1111000}));
    tick();

    // START held high through BUSY with a different V: it must be ignored.
    drive(1'b1, 8'd100);
    tick();
    busies = 0;
    dones  = 0;
    drive(1'b1, 8'd42);
    for (int i = 0; i < 8; i++) begin
      if (ifb.BUSY) busies++;
      if (ifb.DONE) dones++;
      tick();
    end
    drive(1'b0, 8'd0);
    chk("hold_busy_cycles", 64'(busies), 64'd8);
    chk("hold_done_early", 64'(dones), 64'd0);
    chk("hold_done", 64'(ifb.DONE), 64'd1);
    check_result("hold", 100);
    tick();
    chk("hold_no_restart_busy", 64'(ifb.BUSY), 64'd0);
    chk("hold_no_second_done", 64'(ifb.DONE), 64'd0);
    chk("hold_bcd_kept", 64'(ifb.BCD), 64'h100);
    $display("hold: V=100 with START held, BCD=%03h", ifb.BCD);

    // Back-to-back: START presented in the FIN cycle.
    run("pre42", 5);
    drive(1'b1, 8'd42);
    tick();
    drive(1'b0, 8'd0);
    wait_done("fin42", lat);
    chk("fin42_bcd_lit", 64'(ifb.BCD), 64'h042);
    chk("fin42_hex_b_lit", 64'(ifb.HEX), 64'({SB, 7'b0011001, 7'b0100100}));
    check_result("fin42", 42);
    $display("fin-start: V=42 BCD=%03h latency=%0d", ifb.BCD, lat);
    tick();

    // Sweep of every input value, chained through FIN-cycle starts.
    drive(1'b1, 8'd0);
    tick();
    for (int v = 0; v < 256; v++) begin
      drive(1'b0, 8'd0);
      wait_done("sweep", lat);
      check_result("sweep", v);
      $display("sweep: V=%0d BCD=%03h latency=%0d", v, ifb.BCD, lat);
      if (v < 255) begin
        drive(1'b1, 8'(v + 1));
        tick();
      end
    end
    drive(1'b0, 8'd0);
    tick();

    // Reset in the middle of converting 199: outputs return to reset values at once.
    drive(1'b1, 8'd199);
    tick();
    drive(1'b0, 8'd0);
    repeat (4) tick();
    chk("abort_busy_before", 64'(ifb.BUSY), 64'd1);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("abort_bcd_b", 64'(ifb.BCD), 64'h000);
    chk("abort_bcd_n", 64'(ifn.BCD), 64'h000);
    chk("abort_hex_b", 64'(ifb.HEX), 64'({SB, SB, S0}));
    chk("abort_hex_n", 64'(ifn.HEX), 64'({S0, S0, S0}));
    chk("abort_busy", 64'(ifb.BUSY), 64'd0);
    chk("abort_done", 64'(ifb.DONE), 64'd0);
    repeat (2) tick();
    RESET_N = 1'b1;
    dones  = 0;
    busies = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (ifb.DONE || ifn.DONE) dones++;
      if (ifb.BUSY || ifn.BUSY) busies++;
    end
    chk("abort_no_done", 64'(dones), 64'd0);
    chk("abort_no_busy", 64'(busies), 64'd0);
    chk("abort_bcd_stays", 64'(ifb.BCD), 64'h000);
    $display("abort: V=199 reset at iteration 4, BCD=%03h", ifb.BCD);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
